step_scheduler: RTL and testbench
=================================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 12_500_000, meaning cycles between steps at speed level 0.
REQ-002 SHALL have parameter PERIOD_DEC, default 1_000_000, meaning period reduction per speed level.
REQ-003 SHALL have parameter MIN_PERIOD, default 3_000_000, meaning floor on the step period.
REQ-004 SHALL have parameter APPLES_PER_LEVEL, default 4, meaning add_cube pulses per speed-level increment.
REQ-005 SHALL have parameter DONE_TIMEOUT, default 1024, meaning cycles to wait for step_done before giving up.
REQ-006 SHALL have port clk  in  1  system clock, single clock domain.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port game_status  in  2  00 START, 01 PLAY, 10 DIE, 11 RESTART.
REQ-009 SHALL have ports left_press, right_press, up_press, down_press  in  1 each  one-cycle debounced key pulses.
REQ-010 SHALL have port add_cube  in  1  one-cycle apple-eaten pulse.
REQ-011 SHALL have port step_done  in  1  one-cycle pulse from the snake datapath when the body shift completes.
REQ-012 SHALL have port step_req  out  1  one-cycle pulse commanding one snake move.
REQ-013 SHALL have port dir  out  2  committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-014 SHALL have port speed_level  out  3  current speed level, 0..7.
REQ-015 SHALL have port step_busy  out  1  high from step_req until step_done or timeout.
REQ-016 SHALL have port step_timeout  out  1  sticky flag, set when DONE_TIMEOUT expires.

Function
REQ-017 SHALL implement FSM states IDLE, COUNT, REQ, WAIT_DONE.
REQ-018 IDLE -> COUNT when game_status==PLAY; period counter cleared on entry.
REQ-019 COUNT: counter increments each cycle; at counter==period-1 -> REQ.
REQ-020 REQ: lasts exactly one cycle; step_req=1; dir<=pending_dir in the same cycle; -> WAIT_DONE.
REQ-021 WAIT_DONE: step_busy=1; on step_done -> COUNT with counter=0; on DONE_TIMEOUT cycles without step_done -> COUNT, step_timeout<=1.
REQ-022 step_done outside WAIT_DONE SHALL be ignored.
REQ-023 game_status!=PLAY in COUNT -> IDLE, counter cleared; in WAIT_DONE, FSM completes the handshake, then -> IDLE.
REQ-024 period = max(BASE_PERIOD - speed_level*PERIOD_DEC, MIN_PERIOD), computed in 32-bit unsigned arithmetic without underflow.
REQ-025 Key arbitration: only the first accepted press after each step_req updates pending_dir; later presses are ignored until the next step_req.
REQ-026 Simultaneous presses: priority up > down > left > right.
REQ-027 A press opposite to the committed dir (reversal) SHALL be ignored and does not consume the per-step acceptance.
REQ-028 Key presses SHALL be accepted only while game_status==PLAY.
REQ-029 add_cube increments apple_cnt; at apple_cnt==APPLES_PER_LEVEL-1, apple_cnt wraps to 0 and speed_level increments, saturating at 7.
REQ-030 add_cube during REQ or WAIT_DONE SHALL be counted, and the new period SHALL apply from the next COUNT.
REQ-031 game_status==RESTART SHALL clear speed_level, apple_cnt, step_timeout and the counter, set dir=pending_dir=11, force the FSM to IDLE, and abort any pending handshake.

Reset
REQ-032 On rst==0 at a clk edge: state=IDLE, counter=0, step_req=0, step_busy=0, step_timeout=0, dir=pending_dir=11 (right), speed_level=0, apple_cnt=0, acceptance flag cleared.
REQ-033 Reset asserted mid-handshake SHALL drop step_busy the next cycle, without waiting for step_done.

Structure
REQ-034 The game_status encodings, direction encodings and FSM state encodings SHALL live in shared package snake_pkg.
REQ-035 Key arbitration (priority, reversal filter, once-per-step latch) SHALL be sub-module dir_arbiter; the FSM, period counter and speed logic stay in step_scheduler.

Verification (BASE_PERIOD=20, PERIOD_DEC=4, MIN_PERIOD=8, APPLES_PER_LEVEL=2, DONE_TIMEOUT=6)
REQ-036 PLAY from reset, step_done returned 2 cycles after each step_req -> step_req pulses every 23 cycles, dir=11.
REQ-037 dir=11; left_press then up_press in the same step -> left ignored (reversal), next step dir=00; a subsequent down_press in that step is ignored.
REQ-038 up_press and left_press in the same cycle -> next step dir=00.
REQ-039 Eight add_cube pulses -> speed_level=4, period=8 (floored); sixteen pulses -> speed_level=7, period still 8.
REQ-040 step_done withheld -> step_busy high for 6 cycles, step_timeout=1, counting resumes.
REQ-041 RESTART asserted during WAIT_DONE -> next cycle IDLE, step_busy=0, speed_level=0, dir=11.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings and period helper for the snake step scheduler
package snake_pkg;

    typedef logic [1:0] gs_t;
    typedef logic [1:0] dir_t;

    localparam gs_t GS_START   = 2'b00;
    localparam gs_t GS_PLAY    = 2'b01;
    localparam gs_t GS_DIE     = 2'b10;
    localparam gs_t GS_RESTART = 2'b11;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_COUNT = 2'b01;
    localparam logic [1:0] S_REQ   = 2'b10;
    localparam logic [1:0] S_WAIT  = 2'b11;

    // Up/down and left/right differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

    // The floor test is done before subtracting, so the 32-bit math never underflows.
    function automatic logic [31:0] step_period(input logic [31:0] base, input logic [31:0] dec,
                                                input logic [31:0] minp, input logic [2:0] lvl);
        logic [31:0] red;
        red = 32'(lvl) * dec;
        return (red < base && base - red > minp) ? base - red : minp;
    endfunction

endpackage

// File: rtl/step_scheduler_if.sv
// step_scheduler_if: game-side inputs and step handshake outputs of the scheduler
interface step_scheduler_if;
    import snake_pkg::*;

    gs_t        game_status;
    logic       left_press;
    logic       right_press;
    logic       up_press;
    logic       down_press;
    logic       add_cube;
    logic       step_done;
    logic       step_req;
    dir_t       dir;
    logic [2:0] speed_level;
    logic       step_busy;
    logic       step_timeout;

    modport master (
        output game_status, left_press, right_press, up_press, down_press, add_cube, step_done,
        input  step_req, dir, speed_level, step_busy, step_timeout
    );

    modport slave (
        input  game_status, left_press, right_press, up_press, down_press, add_cube, step_done,
        output step_req, dir, speed_level, step_busy, step_timeout
    );

endinterface

// File: rtl/step_scheduler_dir_arbiter.sv
// dir_arbiter: once-per-step key acceptance with priority and reversal filtering
module dir_arbiter
    import snake_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic play,
    input  logic restart,
    input  logic commit,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output dir_t dir
);

    dir_t       dir_q, dir_d, pend_q, pend_d, ref_dir, sel;
    logic       acc_q, acc_d, take;
    logic [3:0] hit;

    // Filter out the reversal of the direction about to be committed, then pick by priority.
    always_comb begin
        ref_dir = commit ? pend_q : dir_q;
        hit     = {up, down, left, right} & ~(4'b1000 >> opposite(ref_dir));
        sel     = hit[3] ? DIR_UP : hit[2] ? DIR_DOWN : hit[1] ? DIR_LEFT : DIR_RIGHT;
        take    = play && |hit && !(acc_q && !commit);
        pend_d  = restart ? DIR_RIGHT : take ? sel : pend_q;
        acc_d   = !restart && (take || (acc_q && !commit));
        dir_d   = restart ? DIR_RIGHT : commit ? pend_q : dir_q;
    end

    // Direction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q  <= DIR_RIGHT;
            pend_q <= DIR_RIGHT;
            acc_q  <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            pend_q <= pend_d;
            acc_q  <= acc_d;
        end
    end

    assign dir = dir_q;

endmodule

// File: rtl/step_scheduler.sv
// step_scheduler: paces snake moves, runs the step handshake and tracks speed
module step_scheduler
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD      = 12_500_000,
    parameter int unsigned PERIOD_DEC       = 1_000_000,
    parameter int unsigned MIN_PERIOD       = 3_000_000,
    parameter int unsigned APPLES_PER_LEVEL = 4,
    parameter int unsigned DONE_TIMEOUT     = 1024
)(
    input logic           clk,
    input logic           rst,
    step_scheduler_if.slave bus
);

    localparam int AW = APPLES_PER_LEVEL > 1 ? $clog2(APPLES_PER_LEVEL) : 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   cnt_q, cnt_d, period;
    logic          to_q, to_d;
    logic [2:0]    spd_q, spd_d;
    logic [AW-1:0] apl_q, apl_d;
    logic          play, restart, wrap;

    assign play    = bus.game_status == GS_PLAY;
    assign restart = bus.game_status == GS_RESTART;
    assign period  = step_period(BASE_PERIOD, PERIOD_DEC, MIN_PERIOD, spd_q);

    // Step FSM; the same counter paces COUNT and times out WAIT, and RESTART overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: if (play) begin
                state_d = S_COUNT;
                cnt_d   = '0;
            end
            S_COUNT: begin
                if (!play) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= period - 32'd1) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 32'd1;
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            default: begin
                if (bus.step_done || cnt_q == DONE_TIMEOUT - 1) begin
                    state_d = play ? S_COUNT : S_IDLE;
                    cnt_d   = '0;
                    to_d    = to_q | !bus.step_done;
                end else cnt_d = cnt_q + 32'd1;
            end
        endcase
        if (restart) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            to_d    = 1'b0;
        end
    end

    // Apple counting and saturating speed level; counted in every state.
    always_comb begin
        wrap  = apl_q == AW'(APPLES_PER_LEVEL - 1);
        apl_d = apl_q;
        spd_d = spd_q;
        if (restart) begin
            apl_d = '0;
            spd_d = '0;
        end else if (bus.add_cube) begin
            apl_d = wrap ? '0 : apl_q + AW'(1);
            spd_d = wrap && spd_q != 3'd7 ? spd_q + 3'd1 : spd_q;
        end
    end

    // Scheduler registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            spd_q   <= '0;
            apl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            spd_q   <= spd_d;
            apl_q   <= apl_d;
        end
    end

    dir_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .play   (play),
        .restart(restart),
        .commit (bus.step_req),
        .up     (bus.up_press),
        .down   (bus.down_press),
        .left   (bus.left_press),
        .right  (bus.right_press),
        .dir    (bus.dir)
    );

    assign bus.step_req     = state_q == S_REQ;
    assign bus.step_busy    = state_q == S_WAIT;
    assign bus.step_timeout = to_q;
    assign bus.speed_level  = spd_q;

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: scoreboard bench checking step cadence, direction and speed
module tb_step_scheduler;
    import snake_pkg::*;

    typedef struct {
        int         gap;
        logic [1:0] dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_req = 0;
    int   last_req = 0;
    int   gap = 0;
    int   run = 0;
    int   busy_run = 0;
    int   dcnt = 0;
    bit   chk_pend = 0;
    bit   done_en = 1;
    exp_t sb[$];

    step_scheduler_if bus();

    step_scheduler #(
        .BASE_PERIOD(20), .PERIOD_DEC(4), .MIN_PERIOD(8), .APPLES_PER_LEVEL(2), .DONE_TIMEOUT(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int g, input logic [1:0] d);
        exp_t e;
        e.gap = g;
        e.dir = d;
        sb.push_back(e);
    endtask

    task automatic wait_steps(input int k);
        int tgt = n_req + k;
        int b = 0;
        while (n_req < tgt && b < 200 * k) begin
            @(negedge clk);
            b++;
        end
        if (n_req < tgt) chk("step_wait", n_req, tgt);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        {bus.up_press, bus.down_press, bus.left_press, bus.right_press} = k;
        @(negedge clk);
        {bus.up_press, bus.down_press, bus.left_press, bus.right_press} = 4'b0000;
    endtask

    task automatic add_cubes(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.add_cube = 1'b1;
            @(negedge clk);
            bus.add_cube = 1'b0;
        end
    endtask

    // Scoreboard monitor: pop one expectation per step_req and check the committed dir and spacing.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (chk_pend) begin
            chk_pend = 0;
            chk("sb_depth", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.gap != 0) chk("step_gap", gap, e.gap);
                chk("step_dir", bus.dir, e.dir);
            end
        end
        if (bus.step_req === 1'b1) begin
            gap      = cyc - last_req;
            last_req = cyc;
            chk_pend = 1;
            n_req++;
        end
        if (bus.step_busy === 1'b1) run++;
        else begin
            if (run > 0) busy_run = run;
            run = 0;
        end
    end

    // Snake datapath model: answer each step_req with step_done two cycles later.
    initial begin
        bus.step_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.step_done = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) bus.step_done = 1'b1;
            end
            if (bus.step_req === 1'b1 && done_en) dcnt = 2;
        end
    end

    initial begin
        rst = 1'b0;
        bus.game_status = GS_START;
        {bus.up_press, bus.down_press, bus.left_press, bus.right_press} = 4'b0000;
        bus.add_cube = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", bus.step_req, 0);
        chk("rst_busy", bus.step_busy, 0);
        chk("rst_timeout", bus.step_timeout, 0);
        chk("rst_dir", bus.dir, DIR_RIGHT);
        chk("rst_speed", bus.speed_level, 0);
        rst = 1'b1;
        @(negedge clk);

        bus.game_status = GS_PLAY;
        push(0, DIR_RIGHT);
        push(23, DIR_RIGHT);
        push(23, DIR_RIGHT);
        wait_steps(3);

        push(23, DIR_UP);
        press(4'b0010);
        press(4'b1000);
        press(4'b0100);
        wait_steps(1);
        push(23, DIR_LEFT);
        press(4'b0100);
        press(4'b0010);
        wait_steps(1);
        push(23, DIR_UP);
        press(4'b1010);
        wait_steps(1);
        push(23, DIR_LEFT);
        press(4'b0011);
        wait_steps(1);
        push(23, DIR_DOWN);
        press(4'b0101);
        wait_steps(1);

        bus.game_status = GS_START;
        add_cubes(8);
        @(negedge clk);
        chk("speed_8", bus.speed_level, 4);
        bus.game_status = GS_PLAY;
        push(0, DIR_DOWN);
        push(11, DIR_DOWN);
        push(11, DIR_DOWN);
        wait_steps(3);
        bus.game_status = GS_START;
        add_cubes(8);
        @(negedge clk);
        chk("speed_16", bus.speed_level, 7);
        bus.game_status = GS_PLAY;
        push(0, DIR_DOWN);
        push(11, DIR_DOWN);
        wait_steps(2);

        done_en = 0;
        push(11, DIR_DOWN);
        push(15, DIR_DOWN);
        wait_steps(2);
        chk("busy_len", busy_run, 6);
        chk("timeout_flag", bus.step_timeout, 1);
        chk("busy_in_wait", bus.step_busy, 1);

        bus.game_status = GS_RESTART;
        @(negedge clk);
        chk("rs_busy", bus.step_busy, 0);
        chk("rs_speed", bus.speed_level, 0);
        chk("rs_dir", bus.dir, DIR_RIGHT);
        chk("rs_timeout", bus.step_timeout, 0);
        chk("rs_req", bus.step_req, 0);

        bus.game_status = GS_START;
        press(4'b1000);
        @(negedge clk);
        bus.game_status = GS_PLAY;
        push(0, DIR_RIGHT);
        wait_steps(1);
        chk("busy_pre_rst", bus.step_busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("busy_post_rst", bus.step_busy, 0);
        chk("req_post_rst", bus.step_req, 0);
        rst = 1'b1;
        bus.game_status = GS_START;
        repeat (3) @(negedge clk);
        chk("sb_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
